// File: rtl/data_mem_if.sv
// Request/response bundle between the memory stage (master) and the data-memory responder (slave).
interface data_mem_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_write;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_write, rsp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_write, rsp_rdata
  );
endinterface

// File: rtl/data_mem_responder.sv
// Word-addressed data memory with fixed access latency, one outstanding request,
// and a sequential bulk-preload port for loading program data before run.
module data_mem_responder #(
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 2
) (
  input  logic              clock,
  input  logic              reset,
  data_mem_if.slave         bus,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_done,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP, LOAD} state_t;

  localparam int              DEPTH      = 2 ** ADDR_W;
  localparam logic [3:0]      CNT_INIT   = 4'(LATENCY - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
  // With a single-cycle latency the countdown is skipped entirely.
  localparam state_t          AFTER_ACCEPT = (LATENCY == 1) ? RESP : WAIT;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                write_q, write_d;
  logic [ADDR_W-1:0]   load_addr_q, load_addr_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_write_q, rsp_write_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                load_done_q, load_done_d;

  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;

  // Next-state, memory write port and response register updates.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    write_d     = write_q;
    load_addr_d = load_addr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    load_done_d = 1'b0;
    mem_we      = 1'b0;
    mem_waddr   = bus.req_addr;
    mem_wdata   = bus.req_wdata;

    case (state_q)
      IDLE: begin
        if (load_start) begin
          state_d     = LOAD;
          load_addr_d = '0;
        end else if (bus.req_valid) begin
          // Stores commit at accept so a following load sees the new data.
          addr_d  = bus.req_addr;
          write_d = bus.req_write;
          cnt_d   = CNT_INIT;
          mem_we  = bus.req_write;
          state_d = AFTER_ACCEPT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = RESP;
        end
      end
      RESP: begin
        // First RESP cycle registers the response; it then holds until taken.
        if (!rsp_valid_q) begin
          rsp_valid_d = 1'b1;
          rsp_write_d = write_q;
          rsp_rdata_d = write_q ? '0 : mem_q[addr_q];
        end else if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_write_d = 1'b0;
          rsp_rdata_d = '0;
          state_d     = IDLE;
        end
      end
      LOAD: begin
        if (load_valid) begin
          mem_we      = 1'b1;
          mem_waddr   = load_addr_q;
          mem_wdata   = load_data;
          load_addr_d = load_addr_q + 1'b1;
          if (load_last || (load_addr_q == ADDR_LAST)) begin
            state_d     = IDLE;
            load_done_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and response registers, cleared by the asynchronous reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      load_addr_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      load_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      load_addr_q <= load_addr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      load_done_q <= load_done_d;
    end
  end

  // Latched request fields; only meaningful while a request is outstanding.
  always_ff @(posedge clock) begin
    addr_q  <= addr_d;
    write_q <= write_d;
  end

  // Storage array; contents survive reset.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign bus.req_ready = (state_q == IDLE) && !load_start;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_write = rsp_write_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign load_done     = load_done_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed plus randomized bench for data_mem_responder against an array-based reference model.
module tb_data_mem_responder;

  localparam int LAT = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        load_start = 1'b0;
  logic        load_valid = 1'b0;
  logic [31:0] load_data  = '0;
  logic        load_last  = 1'b0;
  logic        load_done;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] ref_mem [128];
  logic [31:0] pl_data [128];

  data_mem_if #(.ADDR_W(7), .DATA_W(32)) bus ();

  data_mem_responder #(.ADDR_W(7), .DATA_W(32), .LATENCY(LAT)) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus),
    .load_start (load_start),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_last  (load_last),
    .load_done  (load_done),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One complete request/response transaction, response held off for 'stall' cycles.
  task automatic do_req(input logic wr, input logic [6:0] a, input logic [31:0] d, input int stall);
    logic [31:0] exp;
    chk("req_ready_before", {31'd0, bus.req_ready}, 32'd1);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = a;
    bus.req_wdata = d;
    tick();
    bus.req_valid = 1'b0;
    bus.req_wdata = $urandom;
    if (wr) ref_mem[a] = d;
    exp = wr ? 32'd0 : ref_mem[a];
    for (int k = 0; k < LAT; k++) begin
      chk("rsp_valid_early", {31'd0, bus.rsp_valid}, 32'd0);
      chk("busy_pending", {31'd0, busy}, 32'd1);
      tick();
    end
    chk("rsp_valid_at_latency", {31'd0, bus.rsp_valid}, 32'd1);
    chk("rsp_write", {31'd0, bus.rsp_write}, {31'd0, wr});
    chk("rsp_rdata", bus.rsp_rdata, exp);
    for (int k = 0; k < stall; k++) begin
      chk("req_ready_in_resp", {31'd0, bus.req_ready}, 32'd0);
      tick();
      chk("rsp_valid_hold", {31'd0, bus.rsp_valid}, 32'd1);
      chk("rsp_rdata_hold", bus.rsp_rdata, exp);
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("rsp_valid_after_take", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rsp_rdata_after_take", bus.rsp_rdata, 32'd0);
    chk("rsp_write_after_take", {31'd0, bus.rsp_write}, 32'd0);
    chk("busy_after_take", {31'd0, busy}, 32'd0);
    chk("req_ready_after_take", {31'd0, bus.req_ready}, 32'd1);
  endtask

  // Preload n words of pl_data starting at address 0, with random idle gaps.
  task automatic do_preload(input int n, input bit use_last);
    int addr;
    bit term;
    load_start = 1'b1;
    #1;
    chk("req_ready_load_start", {31'd0, bus.req_ready}, 32'd0);
    tick();
    load_start = 1'b0;
    chk("busy_in_load", {31'd0, busy}, 32'd1);
    addr = 0;
    term = 1'b0;
    for (int i = 0; i < n && !term; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        load_valid = 1'b0;
        tick();
        chk("busy_load_gap", {31'd0, busy}, 32'd1);
        chk("load_done_gap", {31'd0, load_done}, 32'd0);
      end
      load_valid = 1'b1;
      load_data  = pl_data[i];
      load_last  = use_last && (i == n - 1);
      tick();
      ref_mem[addr] = pl_data[i];
      term = load_last || (addr == 127);
      addr++;
      if (!term) begin
        chk("load_done_mid", {31'd0, load_done}, 32'd0);
        chk("busy_mid_load", {31'd0, busy}, 32'd1);
      end
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    chk("load_done_pulse", {31'd0, load_done}, 32'd1);
    chk("busy_after_load", {31'd0, busy}, 32'd0);
    tick();
    chk("load_done_one_cycle", {31'd0, load_done}, 32'd0);
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;

    // Reset and idle
    tick();
    tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    chk("idle_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("idle_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("idle_load_done", {31'd0, load_done}, 32'd0);
    chk("idle_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // Full-depth preload without load_last, then a stray beat that must be ignored
    for (int i = 0; i < 128; i++) pl_data[i] = $urandom;
    do_preload(128, 1'b0);
    load_valid = 1'b1;
    load_data  = 32'h0BAD0BAD;
    tick();
    load_valid = 1'b0;
    chk("stray_beat_busy", {31'd0, busy}, 32'd0);
    chk("stray_beat_done", {31'd0, load_done}, 32'd0);
    do_req(1'b0, 7'd0, 32'd0, 0);
    do_req(1'b0, 7'd127, 32'd0, 0);

    // Store then load the same word
    do_req(1'b1, 7'd5, 32'hDEADBEEF, 0);
    do_req(1'b0, 7'd5, 32'd0, 0);

    // Response back-pressure
    do_req(1'b0, 7'd5, 32'd0, 4);

    // Short preload terminated by load_last
    pl_data[0] = 32'h11;
    pl_data[1] = 32'h22;
    pl_data[2] = 32'h33;
    do_preload(3, 1'b1);
    do_req(1'b0, 7'd0, 32'd0, 0);
    do_req(1'b0, 7'd1, 32'd0, 1);
    do_req(1'b0, 7'd2, 32'd0, 0);
    do_req(1'b0, 7'd3, 32'd0, 0);

    // load_start wins over a simultaneous request
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 7'd9;
    bus.req_wdata = 32'hCAFEF00D;
    load_start    = 1'b1;
    #1;
    chk("conflict_req_ready", {31'd0, bus.req_ready}, 32'd0);
    tick();
    bus.req_valid = 1'b0;
    load_start    = 1'b0;
    chk("conflict_busy", {31'd0, busy}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      chk("conflict_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
      tick();
    end
    load_valid = 1'b1;
    load_data  = 32'hA5A5_0001;
    load_last  = 1'b1;
    tick();
    ref_mem[0] = 32'hA5A5_0001;
    load_valid = 1'b0;
    load_last  = 1'b0;
    chk("conflict_load_done", {31'd0, load_done}, 32'd1);
    chk("conflict_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    tick();
    do_req(1'b0, 7'd9, 32'd0, 0);
    do_req(1'b0, 7'd0, 32'd0, 0);

    // Reset while a store is waiting for its response
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 7'd20;
    bus.req_wdata = 32'h1234_5678;
    tick();
    bus.req_valid = 1'b0;
    ref_mem[20] = 32'h1234_5678;
    reset = 1'b0;
    #1;
    chk("rst_wait_busy", {31'd0, busy}, 32'd0);
    chk("rst_wait_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    tick();
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("post_rst_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
      chk("post_rst_idle", {31'd0, busy}, 32'd0);
    end
    do_req(1'b0, 7'd20, 32'd0, 0);

    // Reset part way through a preload keeps the words already written
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    load_valid = 1'b1;
    load_data  = 32'h7777_0000;
    tick();
    load_data  = 32'h7777_0001;
    tick();
    load_valid = 1'b0;
    ref_mem[0] = 32'h7777_0000;
    ref_mem[1] = 32'h7777_0001;
    reset = 1'b0;
    #1;
    chk("rst_load_busy", {31'd0, busy}, 32'd0);
    chk("rst_load_done", {31'd0, load_done}, 32'd0);
    tick();
    reset = 1'b1;
    tick();
    do_req(1'b0, 7'd1, 32'd0, 0);
    do_req(1'b0, 7'd2, 32'd0, 0);

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      do_req(1'($urandom_range(0, 1)), 7'($urandom_range(0, 127)), $urandom,
             $urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
